// File: rtl/mem_io_unit.sv
// Memory-stage bus interface: turns level load/store enables into one bus transaction.
// Three-state FSM (idle, request, done) with a per-access timeout abort.
module mem_io_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [16:0] address,
  input  logic [11:0] write_data,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic        byte_mode,
  output logic [11:0] read_data,
  output logic        stall,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [16:0] bus_addr,
  output logic [11:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [11:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [7:0] CntLimit = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    byte_d  = byte_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_en || wr_en) begin
          state_d = StReq;
          cnt_d   = 8'd0;
          addr_d  = address;
          // A store wins over a load when both enables are raised.
          we_d    = wr_en;
          byte_d  = byte_mode;
          wdata_d = byte_mode ? {4'h0, write_data[7:0]} : write_data;
        end
      end
      StReq: begin
        if (bus_ack) begin
          state_d = StDone;
          if (!we_q) begin
            rdata_d = byte_q ? {{4{bus_rdata[7]}}, bus_rdata[7:0]} : bus_rdata;
          end
        end else if (cnt_q == CntLimit) begin
          state_d = StDone;
          err_d   = 1'b1;
          if (!we_q) begin
            rdata_d = 12'h000;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      addr_q  <= 17'd0;
      wdata_q <= 12'd0;
      rdata_q <= 12'd0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
    end
  end

  assign bus_req   = (state_q == StReq);
  assign stall     = ((state_q == StIdle) && (rd_en || wr_en)) || (state_q == StReq);
  assign bus_err   = err_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign read_data = rdata_q;

endmodule
